// File: rtl/chipmunk_run_sequencer.sv
// ----------------------------------------------------------------------------
// chipmunk_run_sequencer
//
// Host-side controller for one chipmunk core and its single-port program/data
// RAM. The host can load bytes into the RAM and read them back. It can also
// launch a run: the sequencer loads the start PC and releases the core from
// reset. It then waits for the core to halt or for the host to abort, and
// puts the core back into reset. Each run produces a one-byte status response.
//
// Ownership of the RAM port:
//   RUN state        : the core drives address, write data and write enable.
//   every other state: the sequencer drives address and write data, and the
//                      write enable is low only in WRITE.
//
// Optional feature (compile-time macro WATCHDOG_EN):
//   When defined, a run that lasts MAX_RUN cycles without done or abort ends
//   with a timeout status. Priority is done > abort > timeout. When the macro
//   is undefined, a run ends only on done or abort and MAX_RUN is not used.
//
// Parameters
//   addrSize  address width, same as the core
//   CNT_W     width of the run-cycle counter
//   MAX_RUN   watchdog limit in RUN cycles (used only with WATCHDOG_EN)
//
// Ports
//   clk           in   system clock
//   reset         in   async active-low reset
//   host_valid    in   host command valid
//   host_ready    out  command accepted when host_valid && host_ready
//   host_cmd      in   00 WRITE, 01 READ, 10 RUN, 11 NOP
//   host_addr     in   RAM address (WRITE/READ) or start PC (RUN)
//   host_wdata    in   write byte
//   host_abort    in   level; aborts an active run
//   rsp_valid     out  one-cycle response pulse, no backpressure
//   rsp_data      out  READ byte or run status (00 done, 01 timeout, 02 abort)
//   busy          out  high from RUN accept until the run response
//   run_cycles    out  RUN-state cycles of the last run, saturating
//   cpu_reset     out  core reset, active-low
//   cpu_start_pc  out  core start PC
//   cpu_addr      in   core address bus
//   cpu_wdata     in   core write data
//   cpu_we_n      in   core write enable, active-low
//   cpu_done      in   core halted
//   cpu_rdata     out  core read data (always mem_rdata)
//   mem_addr      out  RAM address
//   mem_wdata     out  RAM write data
//   mem_we_n      out  RAM write enable, active-low
//   mem_rdata     in   RAM asynchronous read data
// ----------------------------------------------------------------------------
module chipmunk_run_sequencer #(
   parameter int          addrSize = 12,
   parameter int          CNT_W    = 24,
   parameter int unsigned MAX_RUN  = 32'h000F_FFFF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                host_valid,
   output logic                host_ready,
   input  logic [1:0]          host_cmd,
   input  logic [addrSize-1:0] host_addr,
   input  logic [7:0]          host_wdata,
   input  logic                host_abort,
   output logic                rsp_valid,
   output logic [7:0]          rsp_data,
   output logic                busy,
   output logic [CNT_W-1:0]    run_cycles,
   output logic                cpu_reset,
   output logic [addrSize-1:0] cpu_start_pc,
   input  logic [addrSize-1:0] cpu_addr,
   input  logic [7:0]          cpu_wdata,
   input  logic                cpu_we_n,
   input  logic                cpu_done,
   output logic [7:0]          cpu_rdata,
   output logic [addrSize-1:0] mem_addr,
   output logic [7:0]          mem_wdata,
   output logic                mem_we_n,
   input  logic [7:0]          mem_rdata
);

   // Host command encoding
   localparam logic [1:0] CMD_WRITE = 2'b00;
   localparam logic [1:0] CMD_READ  = 2'b01;
   localparam logic [1:0] CMD_RUN   = 2'b10;

   // Run status codes
   localparam logic [7:0] ST_DONE    = 8'h00;
   localparam logic [7:0] ST_TIMEOUT = 8'h01;
   localparam logic [7:0] ST_ABORT   = 8'h02;

`ifdef WATCHDOG_EN
   localparam bit WATCHDOG = 1'b1;
`else
   localparam bit WATCHDOG = 1'b0;
`endif

   // The counter has not yet been incremented for the current cycle, so
   // comparing against MAX_RUN-1 ends the run after exactly MAX_RUN cycles.
   localparam logic [CNT_W-1:0] TIMEOUT_AT = CNT_W'(MAX_RUN - 32'd1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_PREP,
      S_RUN,
      S_STOP
   } state_t;

   state_t                r_state;
   state_t                w_next;

   logic [addrSize-1:0]   r_addr;
   logic [7:0]            r_wdata;
   logic [addrSize-1:0]   r_start_pc;
   logic [CNT_W-1:0]      r_run_cycles;
   logic                  r_busy;
   logic                  r_rsp_valid;
   logic [7:0]            r_rsp_data;

   logic                  w_accept;
   logic                  w_timeout;
   logic                  w_run_end;
   logic [7:0]            w_status;

   assign w_accept  = (r_state == S_IDLE) && host_valid;
   assign w_timeout = WATCHDOG && (r_run_cycles == TIMEOUT_AT);
   assign w_run_end = (r_state == S_RUN) && (cpu_done || host_abort || w_timeout);

   // Done outranks abort, and abort outranks timeout.
   assign w_status = cpu_done   ? ST_DONE  :
                     host_abort ? ST_ABORT : ST_TIMEOUT;

   // -------------------------------------------------------------------------
   // FSM process 1: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples the values from before the edge, whatever the
      // order of the processes.
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // -------------------------------------------------------------------------
   // FSM process 2: next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: assigning a default before the case makes every path drive
      // w_next, so no latch is inferred.
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (host_valid) begin
               case (host_cmd)
                  CMD_WRITE: w_next = S_WRITE;
                  CMD_READ:  w_next = S_READ;
                  CMD_RUN:   w_next = S_PREP;
                  default:   w_next = S_IDLE;
               endcase
            end
         end
         S_WRITE: w_next = S_IDLE;
         S_READ:  w_next = S_IDLE;
         S_PREP:  w_next = S_RUN;
         S_RUN:   if (w_run_end) w_next = S_STOP;
         S_STOP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM process 3: state-decoded outputs and the RAM port mux
   // -------------------------------------------------------------------------
   always_comb begin
      host_ready = 1'b0;
      cpu_reset  = 1'b0;
      mem_addr   = r_addr;
      mem_wdata  = r_wdata;
      mem_we_n   = 1'b1;
      case (r_state)
         S_IDLE:  host_ready = 1'b1;
         S_WRITE: mem_we_n   = 1'b0;
         S_RUN: begin
            cpu_reset = 1'b1;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we_n  = cpu_we_n;
         end
         // In PREP the core stays in reset while it picks up the start PC.
         // In STOP, holding reset low clears the core's done flag.
         default: ;
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath registers: latched command, run bookkeeping, response
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr       <= '0;
         r_wdata      <= '0;
         r_start_pc   <= '0;
         r_run_cycles <= '0;
         r_busy       <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp_data   <= '0;
      end else begin
         // The response is a single-cycle pulse unless it is set again below.
         r_rsp_valid <= 1'b0;

         if (w_accept) begin
            r_addr  <= host_addr;
            r_wdata <= host_wdata;
            if (host_cmd == CMD_RUN) begin
               r_start_pc   <= host_addr;
               r_run_cycles <= '0;
               r_busy       <= 1'b1;
            end
         end

         // The RAM read is asynchronous. Capturing at the end of READ
         // presents the byte in the following IDLE cycle.
         if (r_state == S_READ) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= mem_rdata;
         end

         if (r_state == S_RUN) begin
            if (r_run_cycles != '1) begin
               r_run_cycles <= r_run_cycles + 1'b1;
            end
            // Registering the status here makes the response visible
            // during the STOP cycle.
            if (w_run_end) begin
               r_rsp_valid <= 1'b1;
               r_rsp_data  <= w_status;
            end
         end

         if (r_state == S_STOP) begin
            r_busy <= 1'b0;
         end
      end
   end

   assign rsp_valid    = r_rsp_valid;
   assign rsp_data     = r_rsp_data;
   assign busy         = r_busy;
   assign run_cycles   = r_run_cycles;
   assign cpu_start_pc = r_start_pc;
   assign cpu_rdata    = mem_rdata;

endmodule

// File: tb/tb_chipmunk_run_sequencer.sv
`timescale 1ns/1ps
module tb_chipmunk_run_sequencer;

   localparam int AW    = 12;
   localparam int CW    = 8;
   localparam int MAXR  = 100;
   localparam int NEVER = 1 << 30;
   localparam int SAT   = (1 << CW) - 1;
`ifdef WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          host_valid;
   logic          host_ready;
   logic [1:0]    host_cmd;
   logic [AW-1:0] host_addr;
   logic [7:0]    host_wdata;
   logic          host_abort;
   logic          rsp_valid;
   logic [7:0]    rsp_data;
   logic          busy;
   logic [CW-1:0] run_cycles;
   logic          cpu_reset;
   logic [AW-1:0] cpu_start_pc;
   logic [AW-1:0] cpu_addr;
   logic [7:0]    cpu_wdata;
   logic          cpu_we_n;
   logic          cpu_done;
   logic [7:0]    cpu_rdata;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic          mem_we_n;
   logic [7:0]    mem_rdata;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   chipmunk_run_sequencer #(
      .addrSize (AW),
      .CNT_W    (CW),
      .MAX_RUN  (MAXR)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .host_valid   (host_valid),
      .host_ready   (host_ready),
      .host_cmd     (host_cmd),
      .host_addr    (host_addr),
      .host_wdata   (host_wdata),
      .host_abort   (host_abort),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .busy         (busy),
      .run_cycles   (run_cycles),
      .cpu_reset    (cpu_reset),
      .cpu_start_pc (cpu_start_pc),
      .cpu_addr     (cpu_addr),
      .cpu_wdata    (cpu_wdata),
      .cpu_we_n     (cpu_we_n),
      .cpu_done     (cpu_done),
      .cpu_rdata    (cpu_rdata),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_we_n     (mem_we_n),
      .mem_rdata    (mem_rdata)
   );

   // Single-port RAM with asynchronous read
   logic [7:0] ram [0:(1<<AW)-1];
   assign mem_rdata = ram[mem_addr];
   always @(posedge clk) if (!mem_we_n) ram[mem_addr] <= mem_wdata;

   // Behavioural stand-in for the core. It counts cycles out of reset,
   // raises done at cycle done_at and writes once at cycle wr_at. While it
   // is held in reset it drives a write with a low enable, which the
   // sequencer must ignore.
   int            cpu_cnt = 0;
   int            done_at = NEVER;
   int            wr_at   = NEVER;
   logic [AW-1:0] wr_addr = '0;
   logic [AW-1:0] rd_addr = 12'h010;
   logic [7:0]    wr_data = 8'hEE;

   always @(posedge clk) begin
      if (!cpu_reset) cpu_cnt <= 0;
      else            cpu_cnt <= cpu_cnt + 1;
   end
   assign cpu_done  = cpu_reset && (cpu_cnt >= done_at);
   assign cpu_we_n  = cpu_reset ? (cpu_cnt != wr_at) : 1'b0;
   assign cpu_addr  = (cpu_cnt == wr_at) ? wr_addr : rd_addr;
   assign cpu_wdata = wr_data;

   // Reference memory contents
   logic [7:0] shadow [0:(1<<AW)-1];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [7:0] d);
      host_valid = 1'b1; host_cmd = 2'b00; host_addr = a; host_wdata = d;
      check("write_accept_ready", host_ready, 1);
      check("write_we_idle", mem_we_n, 1);
      tick();
      host_valid = 1'b0;
      check("write_we_low", mem_we_n, 0);
      check("write_mem_addr", mem_addr, a);
      check("write_mem_wdata", mem_wdata, d);
      check("write_no_rsp", rsp_valid, 0);
      tick();
      check("write_we_released", mem_we_n, 1);
      shadow[a] = d;
   endtask

   task automatic read_tail(input logic [AW-1:0] a);
      tick();
      host_valid = 1'b0;
      check("read_no_early_rsp", rsp_valid, 0);
      check("read_mem_addr", mem_addr, a);
      check("read_we_high", mem_we_n, 1);
      tick();
      check("read_rsp_valid", rsp_valid, 1);
      check("read_rsp_data", rsp_data, shadow[a]);
      tick();
      check("read_rsp_pulse", rsp_valid, 0);
   endtask

   task automatic do_read(input logic [AW-1:0] a);
      host_valid = 1'b1; host_cmd = 2'b01; host_addr = a;
      check("read_accept_ready", host_ready, 1);
      read_tail(a);
   endtask

   // A run ends at the first RUN cycle in which any end condition holds.
   // The priority for choosing the status is done, then abort, then timeout.
   task automatic do_run(input logic [AW-1:0] pc, input int d_at, input int a_at,
                         input int w_at, input logic [AW-1:0] w_addr,
                         input logic [7:0] w_data, input bit hold);
      int         e;
      int         exp_cyc;
      logic [7:0] st;
      e = d_at;
      if (a_at < e) e = a_at;
      if (WD && (MAXR - 1) < e) e = MAXR - 1;
      if (d_at == e)      st = 8'h00;
      else if (a_at == e) st = 8'h02;
      else                st = 8'h01;
      exp_cyc = (e + 1 > SAT) ? SAT : e + 1;

      done_at = d_at; wr_at = w_at; wr_addr = w_addr; wr_data = w_data;
      host_valid = 1'b1; host_cmd = 2'b10; host_addr = pc;
      check("run_accept_ready", host_ready, 1);
      tick();
      if (hold) begin
         host_cmd = 2'b01; host_addr = rd_addr;
      end else begin
         host_valid = 1'b0;
      end
      check("prep_cpu_reset", cpu_reset, 0);
      check("prep_start_pc", cpu_start_pc, pc);
      check("prep_busy", busy, 1);
      check("prep_run_cycles", run_cycles, 0);
      check("prep_ready", host_ready, 0);
      tick();
      for (int i = 0; i <= e; i++) begin
         host_abort = (i >= a_at);
         check("run_cpu_reset", cpu_reset, 1);
         check("run_no_rsp", rsp_valid, 0);
         check("run_busy", busy, 1);
         check("run_ready", host_ready, 0);
         if (i == 0) begin
            check("run_start_pc_stable", cpu_start_pc, pc);
            check("run_mem_addr_cpu", mem_addr, rd_addr);
            check("run_cpu_rdata", cpu_rdata, shadow[rd_addr]);
         end
         if (i == w_at) begin
            check("run_cpu_we", mem_we_n, 0);
            check("run_cpu_waddr", mem_addr, w_addr);
            check("run_cpu_wdata", mem_wdata, w_data);
         end
         tick();
      end
      host_abort = 1'b0;
      if (w_at <= e) shadow[w_addr] = w_data;
      check("stop_rsp_valid", rsp_valid, 1);
      check("stop_status", rsp_data, st);
      check("stop_cpu_reset", cpu_reset, 0);
      check("stop_we_high", mem_we_n, 1);
      check("stop_busy", busy, 1);
      check("stop_ready", host_ready, 0);
      tick();
      check("after_rsp_pulse", rsp_valid, 0);
      check("after_busy", busy, 0);
      check("after_run_cycles", run_cycles, exp_cyc);
      check("after_ready", host_ready, 1);
      check("after_cpu_reset", cpu_reset, 0);
      done_at = NEVER; wr_at = NEVER;
   endtask

   initial begin
      logic [AW-1:0] a;
      logic [7:0]    d;
      int            d_at;
      int            a_at;

      reset = 1'b0; host_valid = 1'b0; host_cmd = 2'b11; host_addr = '0;
      host_wdata = '0; host_abort = 1'b0;
      tick();
      tick();
      check("reset_ready", host_ready, 1);
      check("reset_cpu_reset", cpu_reset, 0);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_rsp_data", rsp_data, 0);
      check("reset_busy", busy, 0);
      check("reset_run_cycles", run_cycles, 0);
      check("reset_start_pc", cpu_start_pc, 0);
      check("reset_mem_we_n", mem_we_n, 1);
      reset = 1'b1;
      tick();

      // Basic load and readback
      do_write(12'h010, 8'hA5);
      do_read(12'h010);

      // NOP is accepted and produces nothing
      host_valid = 1'b1; host_cmd = 2'b11;
      tick();
      host_valid = 1'b0;
      check("nop_ready", host_ready, 1);
      check("nop_we", mem_we_n, 1);
      tick();
      check("nop_no_rsp", rsp_valid, 0);

      // Randomized loads and readbacks
      for (int k = 0; k < 8; k++) begin
         a = AW'($urandom_range(12'h100, 12'h7FF));
         d = 8'($urandom);
         do_write(a, d);
         do_read(a);
      end

      // Halting program loaded at 0x000, run from 0x000
      do_write(12'h000, 8'h83);
      do_run(12'h000, 20, NEVER, 3, 12'h900, 8'h5C, 1'b0);
      do_read(12'h900);
      do_read(12'h010);

      // Endless loop, abort at RUN cycle 50
      do_run(12'h040, NEVER, 50, NEVER, 12'h000, 8'h00, 1'b0);

      // Endless loop: the watchdog ends it at MAX_RUN cycles if enabled.
      // Otherwise there is no response for 1000 cycles, then an abort
      // ends the run and the counter has saturated.
      do_run(12'h080, NEVER, 1000, NEVER, 12'h000, 8'h00, 1'b0);

      // done and abort in the same cycle, with a READ held throughout the run
      do_run(12'h0C0, 30, 30, 5, 12'hA00, 8'h3E, 1'b1);
      check("held_read_ready", host_ready, 1);
      read_tail(rd_addr);
      do_read(12'hA00);

      // Randomized runs
      for (int k = 0; k < 6; k++) begin
         d_at = $urandom_range(3, 60);
         a_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 60)) : NEVER;
         a    = AW'(12'h800 | $urandom_range(0, 12'h7FF));
         d    = 8'($urandom);
         do_run(AW'($urandom), d_at, a_at, $urandom_range(1, 70), a, d, 1'b0);
         do_read(a);
      end
      do_read(12'h010);

      // Reset pulled low in the middle of a run
      host_valid = 1'b1; host_cmd = 2'b10; host_addr = 12'h123;
      tick();
      host_valid = 1'b0;
      tick();
      tick();
      tick();
      check("midrun_running", cpu_reset, 1);
      reset = 1'b0;
      #1;
      check("midrun_cpu_reset", cpu_reset, 0);
      check("midrun_ready", host_ready, 1);
      check("midrun_rsp", rsp_valid, 0);
      check("midrun_busy", busy, 0);
      check("midrun_we", mem_we_n, 1);
      check("midrun_run_cycles", run_cycles, 0);
      tick();
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("post_reset_no_rsp", rsp_valid, 0);
         check("post_reset_ready", host_ready, 1);
      end
      do_read(12'h010);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
